otbn_pq_ctrlspr: RTL and testbench

OTBN_PQ_CTRLSPR -- requirements
Module: otbn_pq_ctrlspr

---
 rtl/otbn_pq_pkg.sv | 23 ++
 rtl/otbn_pq_wrap_ctr.sv | 35 +++
 rtl/otbn_pq_ctrlspr.sv | 162 ++++++++++++++++
 tb/tb_otbn_pq_ctrlspr.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otbn_pq_pkg.sv
// OTBN post-quantum control SPR shared definitions.
// Address map, write operation encoding and the X/Y wrap limit.
package otbn_pq_pkg;

  typedef enum logic [7:0] {
    PqM    = 8'h00,
    PqJ2   = 8'h01,
    PqJ    = 8'h02,
    PqIdx0 = 8'h03,
    PqIdx1 = 8'h04,
    PqMode = 8'h05,
    PqX    = 8'h06,
    PqY    = 8'h07
  } pqctrlspr_e;

  typedef enum logic {
    PqOpWrite   = 1'b0,
    PqOpReadSet = 1'b1
  } pq_wr_op_e;

  localparam logic [2:0] MaxXY = 3'd4;

endpackage

// File: rtl/otbn_pq_wrap_ctr.sv
// 3-bit counter wrapping at MaxXY, with clear, load and increment.
// Loads above MaxXY saturate so the counter never leaves 0..MaxXY.
module otbn_pq_wrap_ctr
  import otbn_pq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic [2:0] ld_val_i,
  input  logic       inc_i,
  output logic [2:0] q_o
);

  logic [2:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc_i) q_d = (q_q == MaxXY) ? 3'd0 : q_q + 3'd1;
    if (ld_i) q_d = (ld_val_i > MaxXY) ? MaxXY : ld_val_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/otbn_pq_ctrlspr.sv
// OTBN post-quantum loop-control SPR file: M, J2, J, Idx0/1, Mode, X, Y.
// Software access has priority over set_idx, which beats increments/shifts.
module otbn_pq_ctrlspr
  import otbn_pq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic        wr_op_i,
  input  logic [7:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_en_i,
  input  logic [7:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  input  logic        sl_m_i,
  input  logic        sl_j2_i,
  input  logic        inc_j_i,
  input  logic        inc_idx_i,
  input  logic        set_idx_i,
  input  logic        inc_x_i,
  input  logic        inc_y_i,
  input  logic        wipe_i,
  output logic        err_o,
  output logic [31:0] m_o,
  output logic [31:0] j2_o,
  output logic [31:0] j_o,
  output logic [31:0] idx0_o,
  output logic [31:0] idx1_o,
  output logic [31:0] mode_o,
  output logic [2:0]  x_o,
  output logic [2:0]  y_o
);

  logic [31:0] m_q, m_d;
  logic [31:0] j2_q, j2_d;
  logic [31:0] j_q, j_d;
  logic [31:0] idx0_q, idx0_d;
  logic [31:0] idx1_q, idx1_d;
  logic [31:0] mode_q, mode_d;
  logic [2:0]  x_q, y_q;
  logic        err_q, err_d;

  logic        wr_legal, rd_legal;
  logic [7:0]  wsel;
  logic [31:0] spr [8];
  logic [31:0] wr_old, wval, j_inc;

  assign wr_legal = wr_addr_i <= 8'(PqY);
  assign rd_legal = rd_addr_i <= 8'(PqY);

  always_comb begin
    wsel = '0;
    if (wr_en_i && wr_legal) wsel[wr_addr_i[2:0]] = 1'b1;
  end

  always_comb begin
    spr[0] = m_q;
    spr[1] = j2_q;
    spr[2] = j_q;
    spr[3] = idx0_q;
    spr[4] = idx1_q;
    spr[5] = mode_q;
    spr[6] = {29'd0, x_q};
    spr[7] = {29'd0, y_q};
  end

  assign rd_data_o = rd_legal ? spr[rd_addr_i[2:0]] : '0;
  assign wr_old    = spr[wr_addr_i[2:0]];
  assign wval      = (wr_op_i == PqOpReadSet) ? (wr_old | wr_data_i) : wr_data_i;
  assign j_inc     = j_q + 32'd1;

  // Later assignments win: shift/increment, then set_idx, then software.
  always_comb begin
    m_d = m_q;
    if (sl_m_i) m_d = {m_q[30:0], 1'b0};
    if (wsel[0]) m_d = wval;

    j2_d = j2_q;
    if (sl_j2_i) j2_d = {1'b0, j2_q[31:1]};
    if (wsel[1]) j2_d = wval;

    j_d = j_q;
    if (inc_j_i) j_d = (j_inc == j2_q) ? '0 : j_inc;
    if (wsel[2]) j_d = wval;

    idx0_d = idx0_q;
    idx1_d = idx1_q;
    if (inc_idx_i) begin
      idx0_d = idx0_q + 32'd1;
      idx1_d = idx1_q + 32'd1;
    end
    if (set_idx_i) begin
      idx0_d = j_q;
      idx1_d = j_q + j2_q;
    end
    if (wsel[3]) idx0_d = wval;
    if (wsel[4]) idx1_d = wval;

    mode_d = wsel[5] ? wval : mode_q;

    err_d = (rd_en_i && !rd_legal) || (wr_en_i && !wr_legal);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q    <= '0;
      j2_q   <= '0;
      j_q    <= '0;
      idx0_q <= '0;
      idx1_q <= '0;
      mode_q <= '0;
      err_q  <= 1'b0;
    end else if (wipe_i) begin
      m_q    <= '0;
      j2_q   <= '0;
      j_q    <= '0;
      idx0_q <= '0;
      idx1_q <= '0;
      mode_q <= '0;
      err_q  <= 1'b0;
    end else begin
      m_q    <= m_d;
      j2_q   <= j2_d;
      j_q    <= j_d;
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
      mode_q <= mode_d;
      err_q  <= err_d;
    end
  end

  otbn_pq_wrap_ctr u_x (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (wipe_i),
    .ld_i     (wsel[6]),
    .ld_val_i (wval[2:0]),
    .inc_i    (inc_x_i),
    .q_o      (x_q)
  );

  otbn_pq_wrap_ctr u_y (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (wipe_i),
    .ld_i     (wsel[7]),
    .ld_val_i (wval[2:0]),
    .inc_i    (inc_y_i),
    .q_o      (y_q)
  );

  assign m_o    = m_q;
  assign j2_o   = j2_q;
  assign j_o    = j_q;
  assign idx0_o = idx0_q;
  assign idx1_o = idx1_q;
  assign mode_o = mode_q;
  assign x_o    = x_q;
  assign y_o    = y_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_otbn_pq_ctrlspr.sv
// Bench for otbn_pq_ctrlspr: directed vector table, reset/wipe
// sequences and randomized traffic against an array-based model.
module tb_otbn_pq_ctrlspr;

  logic        clk_i, rst_ni;
  logic        wr_en_i, wr_op_i, rd_en_i;
  logic [7:0]  wr_addr_i, rd_addr_i;
  logic [31:0] wr_data_i, rd_data_o;
  logic        sl_m_i, sl_j2_i, inc_j_i, inc_idx_i;
  logic        set_idx_i, inc_x_i, inc_y_i, wipe_i;
  logic        err_o;
  logic [31:0] m_o, j2_o, j_o, idx0_o, idx1_o, mode_o;
  logic [2:0]  x_o, y_o;

  otbn_pq_ctrlspr dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_en_i),
    .wr_op_i   (wr_op_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .sl_m_i    (sl_m_i),
    .sl_j2_i   (sl_j2_i),
    .inc_j_i   (inc_j_i),
    .inc_idx_i (inc_idx_i),
    .set_idx_i (set_idx_i),
    .inc_x_i   (inc_x_i),
    .inc_y_i   (inc_y_i),
    .wipe_i    (wipe_i),
    .err_o     (err_o),
    .m_o       (m_o),
    .j2_o      (j2_o),
    .j_o       (j_o),
    .idx0_o    (idx0_o),
    .idx1_o    (idx1_o),
    .mode_o    (mode_o),
    .x_o       (x_o),
    .y_o       (y_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ops bits: sl_m sl_j2 inc_j inc_idx set_idx inc_x inc_y
  localparam logic [6:0] NONE   = 7'h00;
  localparam logic [6:0] SLM    = 7'h40;
  localparam logic [6:0] SLJ2   = 7'h20;
  localparam logic [6:0] INCJ   = 7'h10;
  localparam logic [6:0] INCIDX = 7'h08;
  localparam logic [6:0] SETIDX = 7'h04;
  localparam logic [6:0] INCX   = 7'h02;

  typedef struct {
    logic        wr_en;
    logic        wr_op;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        rd_en;
    logic [7:0]  ra;
    logic [6:0]  ops;
    logic        wipe;
  } ctl_t;

  typedef struct {
    ctl_t        c;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          ri;
    logic [31:0] exp_val;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int unsigned r [8];
  bit          merr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned mread(input logic [7:0] a);
    if (a < 8'd8) return r[int'(a)];
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) r[i] = 0;
    merr = 0;
  endtask

  task automatic model_step(input ctl_t c);
    int unsigned n [8];
    int unsigned wv;
    bit          wl;
    int          a;
    n  = r;
    a  = int'(c.wa);
    wl = c.wr_en && (a < 8);
    wv = 0;
    if (wl) begin
      wv = c.wr_op ? (r[a] | c.wd) : c.wd;
      if (a >= 6) begin
        wv = wv & 7;
        if (wv > 4) wv = 4;
      end
    end
    if (c.ops[6]) n[0] = r[0] << 1;
    if (c.ops[5]) n[1] = r[1] >> 1;
    if (c.ops[4]) n[2] = (r[2] + 1 == r[1]) ? 0 : r[2] + 1;
    if (c.ops[3]) begin
      n[3] = r[3] + 1;
      n[4] = r[4] + 1;
    end
    if (c.ops[2]) begin
      n[3] = r[2];
      n[4] = r[2] + r[1];
    end
    if (c.ops[1]) n[6] = (r[6] == 4) ? 0 : r[6] + 1;
    if (c.ops[0]) n[7] = (r[7] == 4) ? 0 : r[7] + 1;
    if (wl) n[a] = wv;
    merr = (c.rd_en && c.ra >= 8'd8) || (c.wr_en && c.wa >= 8'd8);
    if (c.wipe) begin
      for (int i = 0; i < 8; i++) n[i] = 0;
      merr = 0;
    end
    r = n;
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    case (i)
      0: return m_o;
      1: return j2_o;
      2: return j_o;
      3: return idx0_o;
      4: return idx1_o;
      5: return mode_o;
      6: return {29'd0, x_o};
      default: return {29'd0, y_o};
    endcase
  endfunction

  task automatic drive(input ctl_t c);
    wr_en_i   = c.wr_en;
    wr_op_i   = c.wr_op;
    wr_addr_i = c.wa;
    wr_data_i = c.wd;
    rd_en_i   = c.rd_en;
    rd_addr_i = c.ra;
    sl_m_i    = c.ops[6];
    sl_j2_i   = c.ops[5];
    inc_j_i   = c.ops[4];
    inc_idx_i = c.ops[3];
    set_idx_i = c.ops[2];
    inc_x_i   = c.ops[1];
    inc_y_i   = c.ops[0];
    wipe_i    = c.wipe;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 8; i++)
      chk($sformatf("reg%0d", i), dut_reg(i), r[i]);
    chk("err", {31'd0, err_o}, {31'd0, merr});
  endtask

  task automatic apply(input ctl_t c, output logic [31:0] rd_pre);
    drive(c);
    #1;
    rd_pre = rd_data_o;
    chk("rd_data", rd_data_o, mread(c.ra));
    model_step(c);
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  function automatic ctl_t mkc(input logic we, input logic op,
                               input logic [7:0] wa, input logic [31:0] wd,
                               input logic re, input logic [7:0] ra,
                               input logic [6:0] ops);
    ctl_t c;
    c.wr_en = we; c.wr_op = op; c.wa = wa; c.wd = wd;
    c.rd_en = re; c.ra = ra; c.ops = ops; c.wipe = 1'b0;
    return c;
  endfunction

  function automatic vec_t mk(input ctl_t c, input logic crd,
                              input logic [31:0] erd, input int ri,
                              input logic [31:0] ev, input logic ee);
    vec_t v;
    v.c = c; v.chk_rd = crd; v.exp_rd = erd;
    v.ri = ri; v.exp_val = ev; v.exp_err = ee;
    return v;
  endfunction

  function automatic vec_t w(input logic [7:0] a, input logic [31:0] d,
                             input int ri, input logic [31:0] ev);
    return mk(mkc(1, 0, a, d, 0, 0, NONE), 0, 0, ri, ev, 0);
  endfunction

  function automatic vec_t o(input logic [6:0] ops, input int ri,
                             input logic [31:0] ev);
    return mk(mkc(0, 0, 0, 0, 0, 0, ops), 0, 0, ri, ev, 0);
  endfunction

  function automatic ctl_t rnd();
    ctl_t c;
    c.wr_en = 1'($urandom_range(0, 1));
    c.wr_op = 1'($urandom_range(0, 1));
    c.wa = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 255))
                                       : 8'($urandom_range(0, 7));
    c.wd = ($urandom_range(0, 1) == 1) ? $urandom
                                       : 32'($urandom_range(0, 15));
    c.rd_en = 1'($urandom_range(0, 1));
    c.ra = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 255))
                                       : 8'($urandom_range(0, 7));
    for (int k = 0; k < 7; k++) c.ops[k] = ($urandom_range(0, 2) == 0);
    c.wipe = ($urandom_range(0, 40) == 0);
    return c;
  endfunction

  initial begin
    vec_t        tbl [$];
    logic [31:0] rd_pre;
    ctl_t        c;

    model_reset();
    rst_ni = 1'b0;
    drive(mkc(0, 0, 0, 0, 1, 8'h05, NONE));
    #12;
    compare_all();
    chk("reset_rd", rd_data_o, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // J wraps at J2
    tbl.push_back(w(8'h01, 32'd4, 1, 32'd4));
    tbl.push_back(w(8'h02, 32'd0, 2, 32'd0));
    tbl.push_back(o(INCJ, 2, 32'd1));
    tbl.push_back(o(INCJ, 2, 32'd2));
    tbl.push_back(o(INCJ, 2, 32'd3));
    tbl.push_back(o(INCJ, 2, 32'd0));
    tbl.push_back(o(INCJ, 2, 32'd1));
    // X wraps at 4, write saturates
    tbl.push_back(w(8'h06, 32'd3, 6, 32'd3));
    tbl.push_back(o(INCX, 6, 32'd4));
    tbl.push_back(o(INCX, 6, 32'd0));
    tbl.push_back(o(INCX, 6, 32'd1));
    tbl.push_back(o(INCX, 6, 32'd2));
    tbl.push_back(o(INCX, 6, 32'd3));
    tbl.push_back(o(INCX, 6, 32'd4));
    tbl.push_back(w(8'h06, 32'd7, 6, 32'd4));
    tbl.push_back(mk(mkc(0, 0, 0, 0, 1, 8'h06, NONE), 1, 32'd4, 6, 32'd4, 0));
    // set_idx beats inc_idx
    tbl.push_back(w(8'h02, 32'd3, 2, 32'd3));
    tbl.push_back(w(8'h01, 32'd8, 1, 32'd8));
    tbl.push_back(o(SETIDX | INCIDX, 3, 32'd3));
    tbl.push_back(o(NONE, 4, 32'd11));
    tbl.push_back(o(INCIDX, 3, 32'd4));
    tbl.push_back(o(NONE, 4, 32'd12));
    // write beats shift; shift drops bit 31
    tbl.push_back(w(8'h00, 32'h8000_0001, 0, 32'h8000_0001));
    tbl.push_back(mk(mkc(1, 0, 8'h00, 32'h55, 0, 0, SLM), 0, 0, 0, 32'h55, 0));
    tbl.push_back(o(SLM, 0, 32'hAA));
    // read-set with same-cycle read, illegal accesses
    tbl.push_back(w(8'h05, 32'h0F, 5, 32'h0F));
    tbl.push_back(mk(mkc(1, 1, 8'h05, 32'h30, 1, 8'h05, NONE),
                     1, 32'h0F, 5, 32'h3F, 0));
    tbl.push_back(mk(mkc(0, 0, 0, 0, 1, 8'h99, NONE), 1, 32'd0, 5, 32'h3F, 1));
    tbl.push_back(o(NONE, 5, 32'h3F));
    tbl.push_back(mk(mkc(1, 0, 8'h08, 32'hFFFF, 1, 8'hFF, NONE),
                     1, 32'd0, 0, 32'hAA, 1));
    tbl.push_back(o(NONE, 0, 32'hAA));
    // J2 = 0: free-running wrap
    tbl.push_back(w(8'h01, 32'd0, 1, 32'd0));
    tbl.push_back(w(8'h02, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF));
    tbl.push_back(o(INCJ, 2, 32'd0));
    tbl.push_back(o(INCJ, 2, 32'd1));
    // inc_j compares against pre-shift J2
    tbl.push_back(w(8'h01, 32'd4, 1, 32'd4));
    tbl.push_back(w(8'h02, 32'd3, 2, 32'd3));
    tbl.push_back(o(SLJ2 | INCJ, 2, 32'd0));
    tbl.push_back(o(NONE, 1, 32'd2));

    foreach (tbl[i]) begin
      apply(tbl[i].c, rd_pre);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), rd_pre, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_reg", i), dut_reg(tbl[i].ri), tbl[i].exp_val);
      chk($sformatf("tbl%0d_err", i), {31'd0, err_o}, {31'd0, tbl[i].exp_err});
    end

    // async reset mid-cycle
    for (int i = 0; i < 8; i++)
      apply(mkc(1, 0, 8'(i), (i >= 6) ? 32'd3 : 32'h11 * (i + 1), 0, 0, NONE),
            rd_pre);
    apply(mkc(0, 0, 0, 0, 1, 8'hC0, NONE), rd_pre);
    chk("pre_rst_err", {31'd0, err_o}, 32'd1);
    drive(mkc(0, 0, 0, 0, 1, 8'h05, NONE));
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_rd", rd_data_o, 32'd0);
    drive(mkc(1, 0, 8'h00, 32'h77, 0, 8'h05, INCX));
    @(posedge clk_i);
    #1;
    compare_all();
    #3;
    rst_ni = 1'b1;
    apply(mkc(0, 0, 0, 0, 0, 8'h06, INCX), rd_pre);
    chk("post_rst_x", {29'd0, x_o}, 32'd1);

    // wipe overrides writes and increments, clears err
    for (int i = 0; i < 8; i++)
      apply(mkc(1, 0, 8'(i), (i >= 6) ? 32'd2 : 32'h5A + i, 0, 0, NONE),
            rd_pre);
    apply(mkc(0, 0, 0, 0, 1, 8'hC0, NONE), rd_pre);
    c = mkc(1, 0, 8'h00, 32'h1234, 1, 8'hF0, INCX | INCJ | SLJ2);
    c.wipe = 1'b1;
    apply(c, rd_pre);
    for (int i = 0; i < 8; i++)
      chk($sformatf("wipe_reg%0d", i), dut_reg(i), 32'd0);
    chk("wipe_err", {31'd0, err_o}, 32'd0);
    drive(mkc(0, 0, 0, 0, 1, 8'h05, NONE));
    #1;
    chk("wipe_rd", rd_data_o, 32'd0);

    repeat (600) apply(rnd(), rd_pre);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
